buffer_fill_ctrl: RTL

Sequencing controller directly upstream of the 4-byte packing buffer. On `start` it reads a run of bytes from a byte-wide synchronous memory, writes each group of four into buffer slots 0..3, then presents each completed 32-bit word to the consumer with a valid/ready handshake. It owns the buffer's `init`, `address`, `data_in` and `write` inputs. The first byte of each group, at the lowest memory address, lands in slot 0, so it appears in bits [31:24] of the packed word.

---
 rtl/buffer_fill_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/buffer_fill_ctrl.sv
// buffer_fill_ctrl: loads runs of bytes from memory into a 4-slot packing buffer and hands each packed word to a consumer
module buffer_fill_ctrl #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              buf_init,
   output logic [1:0]        buf_addr,
   output logic [7:0]        buf_data,
   output logic              buf_write,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, PRESENT, DONE} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] ptr, remaining;
   logic [1:0] slot, tag_q;
   logic rd_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         slot      <= '0;
         tag_q     <= '0;
         rd_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_q  <= mem_rd;
         tag_q <= slot;
         if (state == IDLE && start) begin
            ptr       <= base_addr;
            remaining <= word_count;
         end
         if (mem_rd) begin
            ptr  <= ptr + ADDR_W'(1);
            slot <= slot + 2'd1;
         end
         if (word_valid && word_ready) remaining <= remaining - ADDR_W'(1);
      end
   end
   always_comb begin
      state_nxt  = state;
      mem_rd     = 1'b0;
      buf_init   = 1'b0;
      word_valid = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:    state_nxt = start ? CLEAR : IDLE;
         CLEAR: begin
            buf_init  = 1'b1;
            state_nxt = (remaining == '0) ? DONE : FETCH;
         end
         FETCH: begin
            mem_rd    = 1'b1;
            state_nxt = (slot == 2'd3) ? PRESENT : FETCH;
         end
         PRESENT: begin
            // the slot-3 write is still in flight on the first PRESENT cycle
            word_valid = !rd_q;
            if (word_valid && word_ready) state_nxt = (remaining == ADDR_W'(1)) ? DONE : FETCH;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign mem_addr  = mem_rd ? ptr : '0;
   assign buf_write = rd_q;
   assign buf_addr  = rd_q ? tag_q : 2'd0;
   assign buf_data  = rd_q ? mem_data : 8'd0;
   assign busy      = state != IDLE;
endmodule
